// File: rtl/intc_pkg.sv
// Shared types and constants for the interrupt controller.
// Covers FSM states, configuration register addresses and the hazard-unit handshake state.
package intc_pkg;

  localparam int unsigned VEC_W = 14;
  localparam int unsigned CFG_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] CFG_ENABLE  = 2'd0;
  localparam logic [1:0] CFG_GLOBAL  = 2'd1;
  localparam logic [1:0] CFG_PENDING = 2'd2;
  localparam logic [1:0] CFG_VBASE   = 2'd3;

  localparam logic [3:0] HCU_STATE_INTERRUPT = 4'h2;

endpackage

// File: rtl/interrupt_controller_if.sv
// Configuration register bus of the interrupt controller.
// The master drives the write strobe, address and data; the slave returns combinational read data.
interface interrupt_controller_if;
  import intc_pkg::*;

  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [CFG_W-1:0] cfg_wdata;
  logic [CFG_W-1:0] cfg_rdata;

  modport master (output cfg_we, output cfg_addr, output cfg_wdata, input cfg_rdata);
  modport slave  (input cfg_we, input cfg_addr, input cfg_wdata, output cfg_rdata);

endinterface

// File: rtl/interrupt_controller_prio.sv
// Fixed-priority encoder for the interrupt controller.
// Reports whether any source is eligible and returns the lowest eligible index.
module irq_priority_encoder #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_IRQ-1:0] eligible,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  // Scan from the top down so the lowest set bit is the last one to write index.
  always_comb begin
    valid = |eligible;
    index = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-detecting, fixed-priority interrupt controller feeding the hazard control unit.
// Holds one request until the hazard unit enters its Interrupt state, then tracks the ISR until reti.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int unsigned       NUM_IRQ       = 8,
  parameter int unsigned       IRQ_IDX_W     = 3,
  parameter logic [VEC_W-1:0]  VECTOR_BASE   = 14'h0010,
  parameter int unsigned       VECTOR_STRIDE = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_IRQ-1:0]   irq_in,
  interrupt_controller_if.slave cfg,
  input  logic [3:0]           control_state,
  input  logic                 reti,
  output logic                 interrupt,
  output logic [VEC_W-1:0]     interrupt_vector_address,
  output logic                 in_service,
  output logic [IRQ_IDX_W-1:0] active_irq
);

  state_e               state_q, state_d;
  logic [NUM_IRQ-1:0]   irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0]   pending_q, pending_d;
  logic [NUM_IRQ-1:0]   enable_q, enable_d;
  logic                 global_en_q, global_en_d;
  logic [VEC_W-1:0]     vbase_q, vbase_d;
  logic                 interrupt_q, interrupt_d;
  logic [VEC_W-1:0]     vector_q, vector_d;
  logic                 in_service_q, in_service_d;
  logic [IRQ_IDX_W-1:0] active_q, active_d;

  logic [NUM_IRQ-1:0]   rise_c;
  logic [NUM_IRQ-1:0]   eligible_c;
  logic                 elig_valid_c;
  logic [IRQ_IDX_W-1:0] elig_idx_c;
  logic                 unused_cfg_bits;

  assign unused_cfg_bits = ^cfg.cfg_wdata;

  assign rise_c     = irq_in & ~irq_prev_q;
  assign eligible_c = pending_q & enable_q & {NUM_IRQ{global_en_q}};

  irq_priority_encoder #(
    .NUM_IRQ (NUM_IRQ),
    .IDX_W   (IRQ_IDX_W)
  ) u_prio (
    .eligible (eligible_c),
    .valid    (elig_valid_c),
    .index    (elig_idx_c)
  );

  // Register read mux; unused bits read as zero.
  always_comb begin
    cfg.cfg_rdata = '0;
    case (cfg.cfg_addr)
      CFG_ENABLE:  cfg.cfg_rdata = CFG_W'(enable_q);
      CFG_GLOBAL:  cfg.cfg_rdata = CFG_W'(global_en_q);
      CFG_PENDING: cfg.cfg_rdata = CFG_W'(pending_q);
      CFG_VBASE:   cfg.cfg_rdata = CFG_W'(vbase_q);
      default:     cfg.cfg_rdata = '0;
    endcase
  end

  // Next-state logic: FSM, config writes, then edge capture so a new rise always wins a clear.
  always_comb begin
    state_d      = state_q;
    irq_prev_d   = irq_in;
    pending_d    = pending_q;
    enable_d     = enable_q;
    global_en_d  = global_en_q;
    vbase_d      = vbase_q;
    interrupt_d  = interrupt_q;
    vector_d     = vector_q;
    in_service_d = in_service_q;
    active_d     = active_q;

    case (state_q)
      IDLE: begin
        if (elig_valid_c) begin
          active_d    = elig_idx_c;
          vector_d    = VEC_W'(vbase_q + VEC_W'(elig_idx_c) * VEC_W'(VECTOR_STRIDE));
          interrupt_d = 1'b1;
          state_d     = REQUEST;
        end
      end
      REQUEST: begin
        if (control_state == HCU_STATE_INTERRUPT) begin
          interrupt_d           = 1'b0;
          pending_d[active_q]   = 1'b0;
          in_service_d          = 1'b1;
          state_d               = SERVICE;
        end
      end
      SERVICE: begin
        if (reti) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        CFG_ENABLE:  enable_d    = cfg.cfg_wdata[NUM_IRQ-1:0];
        CFG_GLOBAL:  global_en_d = cfg.cfg_wdata[0];
        CFG_PENDING: pending_d   = pending_d & ~cfg.cfg_wdata[NUM_IRQ-1:0];
        CFG_VBASE:   vbase_d     = cfg.cfg_wdata[VEC_W-1:0];
        default:     ;
      endcase
    end

    pending_d = pending_d | rise_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      irq_prev_q   <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      global_en_q  <= 1'b0;
      vbase_q      <= VECTOR_BASE;
      interrupt_q  <= 1'b0;
      vector_q     <= '0;
      in_service_q <= 1'b0;
      active_q     <= '0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      global_en_q  <= global_en_d;
      vbase_q      <= vbase_d;
      interrupt_q  <= interrupt_d;
      vector_q     <= vector_d;
      in_service_q <= in_service_d;
      active_q     <= active_d;
    end
  end

  assign interrupt                = interrupt_q;
  assign interrupt_vector_address = vector_q;
  assign in_service               = in_service_q;
  assign active_irq               = active_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios then random traffic,
// every cycle compared against a behavioural model of the request/service protocol.
module tb_interrupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  irq_in;
  logic [3:0]  control_state;
  logic        reti;
  logic        interrupt;
  logic [13:0] interrupt_vector_address;
  logic        in_service;
  logic [2:0]  active_irq;

  interrupt_controller_if cfg_if ();

  interrupt_controller dut (
    .clock                    (clock),
    .reset                    (reset),
    .irq_in                   (irq_in),
    .cfg                      (cfg_if),
    .control_state            (control_state),
    .reti                     (reti),
    .interrupt                (interrupt),
    .interrupt_vector_address (interrupt_vector_address),
    .in_service               (in_service),
    .active_irq               (active_irq)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a request is either outstanding, being serviced, or neither.
  bit [7:0]  m_pend, m_en, m_prev;
  bit        m_gen;
  bit [13:0] m_base;
  bit        m_req, m_svc;
  int        m_src;
  bit [13:0] m_vec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit [15:0] m_read(input bit [1:0] addr);
    case (addr)
      2'd0:    return {8'h00, m_en};
      2'd1:    return {15'h0, m_gen};
      2'd2:    return {8'h00, m_pend};
      default: return {2'b00, m_base};
    endcase
  endfunction

  task automatic m_update(input bit rst, input bit [7:0] irq, input bit we, input bit [1:0] addr,
                          input bit [15:0] wd, input bit [3:0] cs, input bit rt);
    bit [7:0] elig, np;
    if (rst) begin
      m_pend = 0; m_en = 0; m_prev = 0; m_gen = 0; m_base = 14'h0010;
      m_req = 0; m_svc = 0; m_src = 0; m_vec = 0;
      return;
    end
    np = m_pend;
    if (!m_req && !m_svc) begin
      elig = m_pend & m_en & (m_gen ? 8'hFF : 8'h00);
      if (elig != 0) begin
        for (int i = 0; i < 8; i++) if (elig[i]) begin m_src = i; break; end
        m_vec = 14'((int'(m_base) + m_src * 4) % 16384);
        m_req = 1;
      end
    end else if (m_req) begin
      if (cs == 4'h2) begin m_req = 0; m_svc = 1; np[m_src] = 1'b0; end
    end else if (rt) begin
      m_svc = 0;
    end
    if (we) begin
      case (addr)
        2'd0: m_en = wd[7:0];
        2'd1: m_gen = wd[0];
        2'd2: np = np & ~wd[7:0];
        default: m_base = wd[13:0];
      endcase
    end
    m_pend = np | (irq & ~m_prev);
    m_prev = irq;
  endtask

  // One clock: drive, check the read port, advance model, check registered outputs.
  task automatic step(input bit rst, input bit [7:0] irq, input bit we, input bit [1:0] addr,
                      input bit [15:0] wd, input bit [3:0] cs, input bit rt);
    @(negedge clock);
    reset = rst; irq_in = irq; control_state = cs; reti = rt;
    cfg_if.cfg_we = we; cfg_if.cfg_addr = addr; cfg_if.cfg_wdata = wd;
    #1 chk("cfg_rdata", 32'(cfg_if.cfg_rdata), 32'(m_read(addr)));
    @(posedge clock);
    m_update(rst, irq, we, addr, wd, cs, rt);
    #1;
    chk("interrupt", 32'(interrupt), 32'(m_req));
    chk("in_service", 32'(in_service), 32'(m_svc));
    chk("active_irq", 32'(active_irq), 32'(m_src));
    if (m_req) chk("vector", 32'(interrupt_vector_address), 32'(m_vec));
  endtask

  task automatic tick(input bit [7:0] irq);
    step(0, irq, 0, 2'd0, 16'h0, 4'h0, 0);
  endtask

  task automatic wr(input bit [1:0] addr, input bit [15:0] wd);
    step(0, 8'h00, 1, addr, wd, 4'h0, 0);
  endtask

  task automatic ack();
    step(0, 8'h00, 0, 2'd0, 16'h0, 4'h2, 0);
  endtask

  task automatic do_reti();
    step(0, 8'h00, 0, 2'd0, 16'h0, 4'h0, 1);
  endtask

  task automatic peek(input bit [1:0] addr, input bit [15:0] exp, input string tag);
    cfg_if.cfg_we = 0; cfg_if.cfg_addr = addr;
    #1 chk(tag, 32'(cfg_if.cfg_rdata), 32'(exp));
  endtask

  initial begin
    reset = 1; irq_in = 0; control_state = 0; reti = 0;
    cfg_if.cfg_we = 0; cfg_if.cfg_addr = 0; cfg_if.cfg_wdata = 0;
    m_update(1, 0, 0, 0, 0, 0, 0);

    step(1, 8'h00, 0, 2'd0, 16'h0, 4'h0, 0);
    step(1, 8'h00, 0, 2'd0, 16'h0, 4'h0, 0);
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    chk("rst_in_service", 32'(in_service), 32'd0);
    chk("rst_active", 32'(active_irq), 32'd0);
    peek(2'd3, 16'h0010, "rst_vbase");

    // Single source, basic request and acknowledge
    wr(2'd0, 16'h0004); wr(2'd1, 16'h0001); wr(2'd3, 16'h0010);
    tick(8'h04);
    chk("t1_no_irq_yet", 32'(interrupt), 32'd0);
    tick(8'h00);
    chk("t1_interrupt", 32'(interrupt), 32'd1);
    chk("t1_vector", 32'(interrupt_vector_address), 32'h0018);
    chk("t1_active", 32'(active_irq), 32'd2);
    ack();
    chk("t1_ack_irq", 32'(interrupt), 32'd0);
    chk("t1_in_service", 32'(in_service), 32'd1);
    peek(2'd2, 16'h0000, "t1_pending");
    do_reti();

    // Two sources in the same cycle: lowest index first, the other right after reti
    wr(2'd0, 16'h00FF);
    tick(8'h22); tick(8'h00);
    chk("t2_active1", 32'(active_irq), 32'd1);
    chk("t2_vector1", 32'(interrupt_vector_address), 32'h0014);
    ack(); tick(8'h00);
    do_reti();
    tick(8'h00);
    chk("t2_interrupt5", 32'(interrupt), 32'd1);
    chk("t2_active5", 32'(active_irq), 32'd5);
    chk("t2_vector5", 32'(interrupt_vector_address), 32'h0024);
    ack(); do_reti();

    // Masked source stays pending; W1C loses to a same-cycle rise
    wr(2'd0, 16'h0000);
    tick(8'h08); tick(8'h00); tick(8'h00);
    chk("t3_masked", 32'(interrupt), 32'd0);
    peek(2'd2, 16'h0008, "t3_pending");
    wr(2'd0, 16'h0008);
    tick(8'h00);
    chk("t3_unmasked", 32'(interrupt), 32'd1);
    step(0, 8'h08, 1, 2'd2, 16'h0008, 4'h0, 0);
    peek(2'd2, 16'h0008, "t3_rise_wins");
    wr(2'd2, 16'h00FF);
    ack(); do_reti(); tick(8'h00);

    // No nesting during service
    wr(2'd0, 16'h00FF);
    tick(8'h10); tick(8'h00); ack();
    tick(8'h01); tick(8'h00); tick(8'h00);
    chk("t4_no_nest", 32'(interrupt), 32'd0);
    do_reti(); tick(8'h00);
    chk("t4_src0", 32'(interrupt), 32'd1);
    chk("t4_active0", 32'(active_irq), 32'd0);
    ack(); do_reti();

    // Vector wrap, then reset in the middle of a request
    wr(2'd3, 16'h3FFC); wr(2'd0, 16'h0004);
    tick(8'h04); tick(8'h00);
    chk("t5_wrap", 32'(interrupt_vector_address), 32'h0004);
    tick(8'h80);
    step(1, 8'h00, 0, 2'd0, 16'h0, 4'h0, 0);
    chk("t5_rst_irq", 32'(interrupt), 32'd0);
    peek(2'd2, 16'h0000, "t5_rst_pending");
    peek(2'd3, 16'h0010, "t5_rst_vbase");

    // Disabling globally does not withdraw an outstanding request
    wr(2'd0, 16'h0002); wr(2'd1, 16'h0001);
    tick(8'h02); tick(8'h00);
    wr(2'd1, 16'h0000);
    tick(8'h00); tick(8'h00);
    chk("t6_held", 32'(interrupt), 32'd1);
    ack();
    chk("t6_acked", 32'(interrupt), 32'd0);
    do_reti();

    // Random traffic against the model
    wr(2'd1, 16'h0001);
    for (int n = 0; n < 3000; n++) begin
      bit [3:0] cs;
      cs = ($urandom_range(0, 3) == 0) ? 4'h2 : 4'($urandom);
      step($urandom_range(0, 299) == 0, 8'($urandom & $urandom), $urandom_range(0, 7) == 0,
           2'($urandom), 16'($urandom), cs, $urandom_range(0, 5) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
